// File: rtl/rr_bank_arbiter.sv
// Round-robin bank arbiter: LSB-first pick rotated past the last accepted index, registered grant.
// Latency: one cycle from request to grant; back-to-back grants on a handshake (one per cycle).
// Backpressure: a held grant stays stable until i_grant_ready; the grant is never retracted.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req                 per-bank request vector
//   o_grant_valid         grant held on o_grant_idx / o_grant_onehot
//   o_grant_idx           granted bank index
//   o_grant_onehot        one-hot of o_grant_idx, zero when no grant is held
//   i_grant_ready         consumer accepts the held grant
module rr_bank_arbiter #(
    parameter int VECTOR_WIDTH = 8,
    parameter int PTR_WIDTH    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [VECTOR_WIDTH-1:0] i_req,
    output logic                    o_grant_valid,
    output logic [PTR_WIDTH-1:0]    o_grant_idx,
    output logic [VECTOR_WIDTH-1:0] o_grant_onehot,
    input  logic                    i_grant_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [PTR_WIDTH-1:0]    last_idx, last_idx_nxt;
    logic [PTR_WIDTH-1:0]    grant_idx, grant_idx_nxt;
    logic [VECTOR_WIDTH-1:0] grant_onehot, grant_onehot_nxt;

    logic                    handshake;
    logic [VECTOR_WIDTH-1:0] cand;
    logic [VECTOR_WIDTH-1:0] hi_mask;
    logic [VECTOR_WIDTH-1:0] hi_cand;
    logic [VECTOR_WIDTH-1:0] search_vec;
    logic                    win_vld;
    logic [PTR_WIDTH-1:0]    win_idx;
    logic [VECTOR_WIDTH-1:0] win_onehot;

    // Winner selection. The just-accepted bank is dropped from the candidates
    // for the handshake cycle so a lone requester cannot monopolise the grant.
    always_comb begin
        handshake = (state == HOLD) && i_grant_ready;
        cand      = handshake ? (i_req & ~grant_onehot) : i_req;

        hi_mask = '0;
        for (int k = 0; k < VECTOR_WIDTH; k++) begin
            hi_mask[k] = (k > int'(last_idx));
        end
        hi_cand = cand & hi_mask;

        // Prefer banks above last_idx; otherwise wrap to the lowest candidate.
        search_vec = (|hi_cand) ? hi_cand : cand;
        win_vld    = |cand;
        win_idx    = '0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int k = VECTOR_WIDTH - 1; k >= 0; k--) begin
            if (search_vec[k]) begin
                win_idx = PTR_WIDTH'(k);
            end
        end
        win_onehot = {{(VECTOR_WIDTH-1){1'b0}}, 1'b1} << win_idx;
    end

    always_comb begin
        state_nxt        = state;
        last_idx_nxt     = last_idx;
        grant_idx_nxt    = grant_idx;
        grant_onehot_nxt = grant_onehot;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_idx_nxt    = win_idx;
                    grant_onehot_nxt = win_onehot;
                    state_nxt        = HOLD;
                end
            end
            HOLD: begin
                // Without a handshake the grant holds regardless of i_req.
                if (handshake) begin
                    last_idx_nxt = grant_idx;
                    if (win_vld) begin
                        grant_idx_nxt    = win_idx;
                        grant_onehot_nxt = win_onehot;
                    end else begin
                        grant_onehot_nxt = '0;
                        state_nxt        = IDLE;
                    end
                end
            end
            default: begin
                state_nxt        = IDLE;
                grant_onehot_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            last_idx     <= PTR_WIDTH'(VECTOR_WIDTH - 1);
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            state        <= state_nxt;
            last_idx     <= last_idx_nxt;
            grant_idx    <= grant_idx_nxt;
            grant_onehot <= grant_onehot_nxt;
        end
    end

    assign o_grant_valid  = (state == HOLD);
    assign o_grant_idx    = grant_idx;
    assign o_grant_onehot = grant_onehot;

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Testbench for rr_bank_arbiter: directed scenarios plus randomized traffic
// checked against a circular-search reference model of the arbitration rules.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_rr_bank_arbiter;

    localparam int N  = 8;
    localparam int PW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          rdy;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;

    int checks;
    int failures;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_last;

    rr_bank_arbiter #(
        .VECTOR_WIDTH(N),
        .PTR_WIDTH   (PW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .o_grant_valid (grant_valid),
        .o_grant_idx   (grant_idx),
        .o_grant_onehot(grant_onehot),
        .i_grant_ready (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        bit           nv;
        int           ni;
        int           nl;
        logic [N-1:0] c;
        int           k;
        nv = m_valid;
        ni = m_idx;
        nl = m_last;
        if (rst) begin
            nv = 1'b0;
            ni = 0;
            nl = N - 1;
        end else if (!m_valid || rdy) begin
            c = req;
            if (m_valid) begin
                c[m_idx] = 1'b0;
                nl = m_idx;
            end
            nv = 1'b0;
            // Circular search starting just after the recorded last index.
            for (int off = 1; off <= N; off++) begin
                k = (m_last + off) % N;
                if (c[k] && !nv) begin
                    nv = 1'b1;
                    ni = k;
                end
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m_idx   = ni;
        m_last  = nl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        rdy = 1'b1;
        tick();
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", grant_valid);
        end
        checks++;
        if (grant_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_idx got=%0d exp=0", grant_idx);
        end
        checks++;
        if (grant_onehot !== 8'h00) begin
            failures++;
            $display("FAIL reset_onehot got=%h exp=00", grant_onehot);
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_oh;
        do_reset();
        req = 8'hFF;
        rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_oh = 8'h01 << (i % N);
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== PW'(i % N) || grant_onehot !== exp_oh) begin
                failures++;
                $display("FAIL rotation step=%0d got v=%b idx=%0d oh=%h exp v=1 idx=%0d oh=%h",
                         i, grant_valid, grant_idx, grant_onehot, i % N, exp_oh);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h0C;
        rdy = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 8'h0C : 8'h0E;
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'd2 || grant_onehot !== 8'h04) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got v=%b idx=%0d oh=%h exp v=1 idx=2 oh=04",
                         i, grant_valid, grant_idx, grant_onehot);
            end
        end
        req = 8'h0C;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd3 || grant_onehot !== 8'h08) begin
            failures++;
            $display("FAIL backpressure_release got v=%b idx=%0d oh=%h exp v=1 idx=3 oh=08",
                     grant_valid, grant_idx, grant_onehot);
        end
    endtask

    task automatic test_wrap();
        int exp_seq[3] = '{7, 0, 7};
        do_reset();
        req = 8'h40;
        rdy = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd6) begin
            failures++;
            $display("FAIL wrap_setup got v=%b idx=%0d exp v=1 idx=6", grant_valid, grant_idx);
        end
        tick();
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== PW'(exp_seq[i])) begin
                failures++;
                $display("FAIL wrap step=%0d got v=%b idx=%0d exp v=1 idx=%0d",
                         i, grant_valid, grant_idx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_single();
        bit exp_v;
        do_reset();
        req = 8'h10;
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = (i % 2 == 0);
            checks++;
            if (grant_valid !== exp_v || (exp_v && grant_idx !== 3'd4)
                || grant_onehot !== (exp_v ? 8'h10 : 8'h00)) begin
                failures++;
                $display("FAIL single step=%0d got v=%b idx=%0d oh=%h exp v=%b idx=4",
                         i, grant_valid, grant_idx, grant_onehot, exp_v);
            end
        end
    endtask

    task automatic test_late_arrival();
        do_reset();
        req = 8'h01;
        rdy = 1'b1;
        tick();
        tick();
        req = 8'h03;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd1) begin
            failures++;
            $display("FAIL late_arrival got v=%b idx=%0d exp v=1 idx=1", grant_valid, grant_idx);
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        req = 8'h20;
        rdy = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin
            failures++;
            $display("FAIL reset_hold_setup got v=%b idx=%0d exp v=1 idx=5", grant_valid, grant_idx);
        end
        rst = 1'b1;
        rdy = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold_drop got v=%b oh=%h exp v=0 oh=00", grant_valid, grant_onehot);
        end
        rst = 1'b0;
        rdy = 1'b0;
        req = 8'hFF;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold_restart got v=%b idx=%0d exp v=1 idx=0", grant_valid, grant_idx);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            req = N'($urandom) & N'($urandom);
            // Protocol: a held request stays asserted until accepted.
            if (m_valid) req[m_idx] = 1'b1;
            rdy = ($urandom_range(0, 3) != 0);
            tick();
            exp_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
            checks++;
            if (grant_valid !== m_valid || grant_onehot !== exp_oh
                || (m_valid && grant_idx !== PW'(m_idx))) begin
                failures++;
                $display("FAIL random cyc=%0d got v=%b idx=%0d oh=%h exp v=%b idx=%0d oh=%h",
                         i, grant_valid, grant_idx, grant_onehot, m_valid, m_idx, exp_oh);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_valid  = 1'b0;
        m_idx    = 0;
        m_last   = N - 1;
        rst      = 1'b1;
        req      = '0;
        rdy      = 1'b0;

        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_single();
        test_late_arrival();
        test_reset_hold();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
